// File: rtl/unidade_controle_rodadas.sv
// unidade_controle_rodadas: Moore control FSM for the round-based memory game with per-move timeout
module unidade_controle_rodadas #(
  parameter int unsigned TIMEOUT_CICLOS = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       igual_rodada,
  input  logic       fim_rodadas,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraR,
  output logic       registraR,
  output logic       ganhou,
  output logic       perdeu,
  output logic       pronto,
  output logic       db_timeout,
  output logic [3:0] db_estado
);
  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIA_RODADA  = 4'h2,
    ESPERA_JOGADA  = 4'h3,
    REGISTRA       = 4'h4,
    COMPARA        = 4'h5,
    PROXIMA_JOGADA = 4'h6,
    PROXIMA_RODADA = 4'h7,
    FIM_ACERTOU    = 4'hA,
    FIM_TIMEOUT    = 4'hD,
    FIM_ERROU      = 4'hE
  } estado_t;
  localparam logic [15:0] LIMITE = 16'(TIMEOUT_CICLOS - 1);
  estado_t     estado_q, estado_d;
  logic [15:0] timer_q, timer_d;
  logic        timeout;
  assign timeout = timer_q == LIMITE;
  // state and move timer registers, asynchronously cleared
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= INICIAL;
      timer_q  <= '0;
    end else begin
      estado_q <= estado_d;
      timer_q  <= timer_d;
    end
  end
  // next state; the timer only runs while staying in espera_jogada, so every entry restarts it at 0
  always_comb begin
    estado_d = INICIAL;
    case (estado_q)
      INICIAL:        estado_d = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:     estado_d = INICIA_RODADA;
      INICIA_RODADA:  estado_d = ESPERA_JOGADA;
      ESPERA_JOGADA:  estado_d = jogada ? REGISTRA : timeout ? FIM_TIMEOUT : ESPERA_JOGADA;
      REGISTRA:       estado_d = COMPARA;
      COMPARA:        estado_d = !igual ? FIM_ERROU : !igual_rodada ? PROXIMA_JOGADA :
                                 !fim_rodadas ? PROXIMA_RODADA : FIM_ACERTOU;
      PROXIMA_JOGADA: estado_d = ESPERA_JOGADA;
      PROXIMA_RODADA: estado_d = INICIA_RODADA;
      FIM_ACERTOU:    estado_d = iniciar ? PREPARACAO : FIM_ACERTOU;
      FIM_ERROU:      estado_d = iniciar ? PREPARACAO : FIM_ERROU;
      FIM_TIMEOUT:    estado_d = iniciar ? PREPARACAO : FIM_TIMEOUT;
      default:        estado_d = INICIAL;
    endcase
    timer_d = (estado_q == ESPERA_JOGADA && estado_d == ESPERA_JOGADA) ? timer_q + 16'd1 : '0;
  end
  assign zeraC      = estado_q == PREPARACAO || estado_q == INICIA_RODADA;
  assign contaC     = estado_q == PROXIMA_JOGADA;
  assign zeraE      = estado_q == PREPARACAO;
  assign contaE     = estado_q == PROXIMA_RODADA;
  assign zeraR      = estado_q == PREPARACAO;
  assign registraR  = estado_q == REGISTRA;
  assign ganhou     = estado_q == FIM_ACERTOU;
  assign perdeu     = estado_q == FIM_ERROU || estado_q == FIM_TIMEOUT;
  assign pronto     = ganhou || perdeu;
  assign db_timeout = estado_q == FIM_TIMEOUT;
  assign db_estado  = estado_q;
endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// tb_unidade_controle_rodadas: directed and randomized checks of the round control FSM
module tb_unidade_controle_rodadas;
  localparam int T = 10;
  logic clock = 0, reset = 0, iniciar = 0, jogada = 0, igual = 0, igual_rodada = 0, fim_rodadas = 0;
  logic zeraC, contaC, zeraE, contaE, zeraR, registraR, ganhou, perdeu, pronto, db_timeout;
  logic [3:0] db_estado;
  logic [9:0] outs;
  logic [3:0] m_state = 4'h0;
  int m_wait = 0;
  int cmp = 0, fails = 0;
  assign outs = {zeraC, contaC, zeraE, contaE, zeraR, registraR, ganhou, perdeu, pronto, db_timeout};
  unidade_controle_rodadas #(.TIMEOUT_CICLOS(T)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada), .igual(igual),
    .igual_rodada(igual_rodada), .fim_rodadas(fim_rodadas), .zeraC(zeraC), .contaC(contaC),
    .zeraE(zeraE), .contaE(contaE), .zeraR(zeraR), .registraR(registraR), .ganhou(ganhou),
    .perdeu(perdeu), .pronto(pronto), .db_timeout(db_timeout), .db_estado(db_estado)
  );
  always #5 clock = ~clock;
  // expected output bits {zeraC,contaC,zeraE,contaE,zeraR,registraR,ganhou,perdeu,pronto,db_timeout}
  function automatic logic [9:0] exp_out(input logic [3:0] s);
    case (s)
      4'h1: return 10'b1010100000;
      4'h2: return 10'b1000000000;
      4'h4: return 10'b0000010000;
      4'h6: return 10'b0100000000;
      4'h7: return 10'b0001000000;
      4'hA: return 10'b0000001010;
      4'hE: return 10'b0000000110;
      4'hD: return 10'b0000000111;
      default: return 10'b0;
    endcase
  endfunction
  // game rules: m_wait counts cycles already spent waiting for the current move
  task automatic tick;
    logic [3:0] n;
    @(posedge clock);
    n = m_state;
    if (!reset) n = 4'h0;
    else if (m_state == 4'h0) n = iniciar ? 4'h1 : 4'h0;
    else if (m_state == 4'h1) n = 4'h2;
    else if (m_state == 4'h2) n = 4'h3;
    else if (m_state == 4'h3) n = jogada ? 4'h4 : (m_wait + 1 == T) ? 4'hD : 4'h3;
    else if (m_state == 4'h4) n = 4'h5;
    else if (m_state == 4'h5) n = !igual ? 4'hE : !igual_rodada ? 4'h6 : !fim_rodadas ? 4'h7 : 4'hA;
    else if (m_state == 4'h6) n = 4'h3;
    else if (m_state == 4'h7) n = 4'h2;
    else if (iniciar) n = 4'h1;
    m_wait = (m_state == 4'h3 && n == 4'h3) ? m_wait + 1 : 0;
    m_state = n;
    @(negedge clock);
  endtask
  task automatic test_reset;
    #2;
    cmp++; if ({db_estado, outs} !== 14'h0) begin fails++; $display("FAIL reset_hold: got %h/%b want 0/0", db_estado, outs); end
    @(negedge clock); reset = 1;
    tick();
    cmp++; if ({db_estado, outs} !== 14'h0) begin fails++; $display("FAIL reset_release: got %h/%b want 0/0", db_estado, outs); end
  endtask
  task automatic test_start;
    iniciar = 1; tick(); iniciar = 0;
    cmp++; if ({db_estado, outs} !== {4'h1, 10'b1010100000}) begin fails++; $display("FAIL start_prep: got %h/%b want 1/1010100000", db_estado, outs); end
    tick();
    cmp++; if ({db_estado, outs} !== {4'h2, 10'b1000000000}) begin fails++; $display("FAIL start_inicia: got %h/%b want 2/1000000000", db_estado, outs); end
    tick();
    cmp++; if ({db_estado, outs} !== {4'h3, 10'b0}) begin fails++; $display("FAIL start_espera: got %h/%b want 3/0", db_estado, outs); end
  endtask
  task automatic test_round0;
    jogada = 1; tick(); jogada = 0;
    cmp++; if ({db_estado, outs} !== {4'h4, 10'b0000010000}) begin fails++; $display("FAIL r0_registra: got %h/%b want 4/0000010000", db_estado, outs); end
    igual = 1; igual_rodada = 1; fim_rodadas = 0; tick();
    cmp++; if (db_estado !== 4'h5) begin fails++; $display("FAIL r0_compara: got %h want 5", db_estado); end
    tick();
    cmp++; if ({db_estado, outs} !== {4'h7, 10'b0001000000}) begin fails++; $display("FAIL r0_prox_rodada: got %h/%b want 7/0001000000", db_estado, outs); end
    tick(); tick();
    cmp++; if (db_estado !== 4'h3) begin fails++; $display("FAIL r0_back_espera: got %h want 3", db_estado); end
  endtask
  task automatic test_next_move;
    jogada = 1; tick(); jogada = 0;
    igual = 1; igual_rodada = 0; tick(); tick();
    cmp++; if ({db_estado, outs} !== {4'h6, 10'b0100000000}) begin fails++; $display("FAIL move_prox_jogada: got %h/%b want 6/0100000000", db_estado, outs); end
    tick();
    cmp++; if (db_estado !== 4'h3) begin fails++; $display("FAIL move_back_espera: got %h want 3", db_estado); end
  endtask
  task automatic test_timeout;
    for (int i = 1; i < T; i++) tick();
    cmp++; if (db_estado !== 4'h3) begin fails++; $display("FAIL to_early: got %h want 3 after %0d edges", db_estado, T - 1); end
    tick();
    cmp++; if ({db_estado, outs} !== {4'hD, 10'b0000000111}) begin fails++; $display("FAIL to_fire: got %h/%b want d/0000000111", db_estado, outs); end
    tick();
    cmp++; if (db_estado !== 4'hD) begin fails++; $display("FAIL to_hold: got %h want d", db_estado); end
    iniciar = 1; tick(); iniciar = 0;
    cmp++; if (db_estado !== 4'h1) begin fails++; $display("FAIL to_restart: got %h want 1", db_estado); end
    tick(); tick();
    for (int i = 1; i < T; i++) tick();
    jogada = 1; tick(); jogada = 0;
    cmp++; if (db_estado !== 4'h4) begin fails++; $display("FAIL to_last_cycle_jogada: got %h want 4", db_estado); end
  endtask
  task automatic test_lose;
    igual = 0; tick(); tick();
    cmp++; if ({db_estado, outs} !== {4'hE, 10'b0000000110}) begin fails++; $display("FAIL lose: got %h/%b want e/0000000110", db_estado, outs); end
    iniciar = 1; tick(); iniciar = 0;
    cmp++; if (db_estado !== 4'h1) begin fails++; $display("FAIL lose_restart: got %h want 1", db_estado); end
    tick(); tick();
  endtask
  task automatic test_win;
    jogada = 1; tick(); jogada = 0;
    igual = 1; igual_rodada = 1; fim_rodadas = 1; tick(); tick();
    cmp++; if ({db_estado, outs} !== {4'hA, 10'b0000001010}) begin fails++; $display("FAIL win: got %h/%b want a/0000001010", db_estado, outs); end
    iniciar = 1; tick(); iniciar = 0;
    cmp++; if (db_estado !== 4'h1) begin fails++; $display("FAIL win_restart: got %h want 1", db_estado); end
    tick(); tick();
  endtask
  task automatic test_async_reset;
    cmp++; if (db_estado !== 4'h3) begin fails++; $display("FAIL ar_setup: got %h want 3", db_estado); end
    #1 reset = 0; m_state = 4'h0; m_wait = 0;
    #1;
    cmp++; if ({db_estado, outs} !== 14'h0) begin fails++; $display("FAIL ar_immediate: got %h/%b want 0/0", db_estado, outs); end
    tick();
    @(negedge clock); reset = 1;
    tick(); tick();
    cmp++; if ({db_estado, outs} !== 14'h0) begin fails++; $display("FAIL ar_idle: got %h/%b want 0/0", db_estado, outs); end
  endtask
  task automatic test_random;
    for (int i = 0; i < 3000; i++) begin
      iniciar = $urandom_range(0, 5) == 0;
      jogada = $urandom_range(0, 11) == 0;
      igual = $urandom_range(0, 7) != 0;
      igual_rodada = $urandom_range(0, 2) == 0;
      fim_rodadas = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 299) == 0) begin
        reset = 0; m_state = 4'h0; m_wait = 0;
      end
      tick();
      reset = 1;
      cmp++;
      if ({db_estado, outs} !== {m_state, exp_out(m_state)}) begin
        fails++;
        $display("FAIL random[%0d]: got %h/%b want %h/%b", i, db_estado, outs, m_state, exp_out(m_state));
      end
    end
  endtask
  initial begin
    test_reset();
    test_start();
    test_round0();
    test_next_move();
    test_timeout();
    test_lose();
    test_win();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end
endmodule
